// File: rtl/mem_wb_if.sv
// MEM->WB bundle channel: GPR write lanes plus one HI/LO write, carried
// under a single valid/ready pair.
//
// Handshake: a bundle moves when valid and ready are both 1 at a rising clock edge.
// The sender holds valid and the payload stable until that edge.
// The receiver drives ready without looking at valid on the same channel.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
);
  logic                    valid;
  logic                    ready;
  logic [LANES*ADDR_W-1:0] wd;
  logic [LANES-1:0]        wreg;
  logic [LANES*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]       hi;
  logic [DATA_W-1:0]       lo;
  logic                    whilo;

  modport master (output valid, wd, wreg, wdata, hi, lo, whilo, input ready);
  modport slave  (input valid, wd, wreg, wdata, hi, lo, whilo, output ready);
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, write-lane
// collision resolution on capture, and a retired-bundle counter.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_if.slave          in_if,
  mem_wb_if.master         out_if,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]       hi;
    logic [DATA_W-1:0]       lo;
    logic                    whilo;
  } bundle_t;

  state_t  state;
  bundle_t main_q;
  bundle_t skid_q;
  bundle_t in_res;
  logic    out_valid_q;
  logic    in_ready_q;
  logic    accept;
  logic    consume;

  // Lane k is dropped if it targets r0 or a higher lane writes the same register.
  always_comb begin
    in_res.wd    = in_if.wd;
    in_res.wdata = in_if.wdata;
    in_res.hi    = in_if.hi;
    in_res.lo    = in_if.lo;
    in_res.whilo = in_if.whilo;
    in_res.wreg  = '0;
    for (int k = 0; k < LANES; k++) begin
      in_res.wreg[k] = in_if.wreg[k] && (in_if.wd[k*ADDR_W +: ADDR_W] != '0);
      for (int j = k + 1; j < LANES; j++) begin
        if (in_if.wreg[j] && (in_if.wd[j*ADDR_W +: ADDR_W] == in_if.wd[k*ADDR_W +: ADDR_W]))
          in_res.wreg[k] = 1'b0;
      end
    end
  end

  assign accept  = in_if.valid && in_ready_q;
  assign consume = out_valid_q && out_if.ready;

  // main_q is cleared whenever the block empties, so out_* reads as a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      retire_cnt  <= '0;
    end else begin
      if (consume)
        retire_cnt <= retire_cnt + 1'b1;
      if (flush) begin
        state       <= EMPTY;
        main_q      <= '0;
        skid_q      <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_q      <= in_res;
              out_valid_q <= 1'b1;
              state       <= ONE;
            end
          end
          ONE: begin
            if (accept && consume) begin
              main_q <= in_res;
            end else if (accept) begin
              skid_q     <= in_res;
              in_ready_q <= 1'b0;
              state      <= TWO;
            end else if (consume) begin
              main_q      <= '0;
              out_valid_q <= 1'b0;
              state       <= EMPTY;
            end
          end
          TWO: begin
            if (consume) begin
              main_q     <= skid_q;
              skid_q     <= '0;
              in_ready_q <= 1'b1;
              state      <= ONE;
            end
          end
          default: begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.wd    = main_q.wd;
  assign out_if.wreg  = main_q.wreg;
  assign out_if.wdata = main_q.wdata;
  assign out_if.hi    = main_q.hi;
  assign out_if.lo    = main_q.lo;
  assign out_if.whilo = main_q.whilo;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe with two lanes and a 4-bit retire counter, checked
// against a depth-2 queue model of the buffered bundles.
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;
  localparam int BW     = LANES*ADDR_W + LANES + LANES*DATA_W + 2*DATA_W + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] retire_cnt;
  logic [1:0]       dbg_state;

  mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) in_bus ();
  mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) out_bus ();

  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_if      (in_bus),
    .out_if     (out_bus),
    .retire_cnt (retire_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  // Highest writing lane owns each nonzero address.
  function automatic logic [LANES-1:0] resolve(logic [LANES*ADDR_W-1:0] wd, logic [LANES-1:0] wreg);
    int winner[int];
    logic [LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      if (wreg[l] && wd[l*ADDR_W +: ADDR_W] != 0) winner[int'(wd[l*ADDR_W +: ADDR_W])] = l;
    for (int l = 0; l < LANES; l++)
      if (wreg[l] && wd[l*ADDR_W +: ADDR_W] != 0 && winner[int'(wd[l*ADDR_W +: ADDR_W])] == l) r[l] = 1'b1;
    return r;
  endfunction

  function automatic logic [BW-1:0] dut_out();
    return {out_bus.wd, out_bus.wreg, out_bus.wdata, out_bus.hi, out_bus.lo, out_bus.whilo};
  endfunction

  function automatic logic [BW-1:0] exp_out();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] wd0, input logic [4:0] wd1,
                       input logic [1:0] wreg, input logic [31:0] d0, input logic [31:0] d1);
    in_bus.valid = v;
    in_bus.wd    = {wd1, wd0};
    in_bus.wreg  = wreg;
    in_bus.wdata = {d1, d0};
    in_bus.hi    = $urandom;
    in_bus.lo    = $urandom;
    in_bus.whilo = 1'($urandom_range(0, 1));
  endtask

  // Advances one clock and updates the model; returns at the following negedge.
  task automatic tick();
    logic acc, con;
    logic [BW-1:0] nb;
    acc = in_bus.valid && (exp_q.size() < 2);
    con = out_bus.ready && (exp_q.size() > 0);
    nb  = {in_bus.wd, resolve(in_bus.wd, in_bus.wreg), in_bus.wdata, in_bus.hi, in_bus.lo, in_bus.whilo};
    @(posedge clk);
    if (con) begin
      void'(exp_q.pop_front());
      exp_cnt = exp_cnt + 1'b1;
    end
    if (flush) exp_q.delete();
    else if (acc) exp_q.push_back(nb);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_cnt = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_bus.ready = 1'b1;
    drive(1'b1, 5'd3, 5'd4, 2'b11, 32'h1, 32'h2);
    repeat (3) @(negedge clk);
    n_checks++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_bus.valid); end
    n_checks++; if (out_bus.wreg !== 2'b00) begin n_fail++; $display("FAIL reset_out_wreg: got %b want 00", out_bus.wreg); end
    n_checks++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_bus.ready); end
    n_checks++; if (retire_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retire_cnt: got %0d want 0", retire_cnt); end
    n_checks++; if (dut_out() !== '0) begin n_fail++; $display("FAIL reset_out_fields: got %h want 0", dut_out()); end
    exp_q.delete();
    exp_cnt = '0;
    in_bus.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    out_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(3 + i), 5'd0, 2'b01, $urandom, $urandom);
      tick();
      n_checks++; if (out_bus.valid !== 1'b1 || out_bus.wd[4:0] !== 5'(3 + i)) begin
        n_fail++; $display("FAIL stream_wd%0d: got valid=%b wd=%0d want valid=1 wd=%0d", i, out_bus.valid, out_bus.wd[4:0], 3 + i);
      end
      n_checks++; if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL stream_bundle%0d: got %h want %h", i, dut_out(), exp_out()); end
    end
    in_bus.valid = 1'b0;
    tick();
    n_checks++; if (retire_cnt !== 4'd3) begin n_fail++; $display("FAIL stream_retire: got %0d want 3", retire_cnt); end
    n_checks++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b want 0", out_bus.valid); end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] c0;
    c0 = retire_cnt;
    out_bus.ready = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 2'b01, 32'hAAAA, 32'h0);
    tick();
    drive(1'b1, 5'd10, 5'd0, 2'b01, 32'hBBBB, 32'h0);
    tick();
    in_bus.valid = 1'b0;
    n_checks++; if (in_bus.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", in_bus.ready); end
    n_checks++; if (out_bus.wd[4:0] !== 5'd9) begin n_fail++; $display("FAIL bp_hold_a: got %0d want 9", out_bus.wd[4:0]); end
    tick();
    n_checks++; if (dut_out() !== exp_out() || out_bus.wd[4:0] !== 5'd9) begin n_fail++; $display("FAIL bp_still_a: got %h want %h", dut_out(), exp_out()); end
    out_bus.ready = 1'b1;
    tick();
    n_checks++; if (out_bus.wd[4:0] !== 5'd10 || out_bus.valid !== 1'b1) begin n_fail++; $display("FAIL bp_then_b: got valid=%b wd=%0d want valid=1 wd=10", out_bus.valid, out_bus.wd[4:0]); end
    n_checks++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_free: got %b want 1", in_bus.ready); end
    tick();
    n_checks++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got valid=%b want 0", out_bus.valid); end
    n_checks++; if (retire_cnt !== 4'(c0 + 4'd2)) begin n_fail++; $display("FAIL bp_retire: got %0d want %0d", retire_cnt, 4'(c0 + 4'd2)); end
  endtask

  task automatic test_collision();
    out_bus.ready = 1'b1;
    drive(1'b1, 5'd7, 5'd7, 2'b11, 32'h11, 32'h22);
    tick();
    n_checks++; if (out_bus.wreg !== 2'b10) begin n_fail++; $display("FAIL coll_same_addr: got %b want 10", out_bus.wreg); end
    n_checks++; if (out_bus.wdata[63:32] !== 32'h22) begin n_fail++; $display("FAIL coll_lane1_data: got %h want 22", out_bus.wdata[63:32]); end
    drive(1'b1, 5'd0, 5'd4, 2'b11, 32'h33, 32'h44);
    tick();
    n_checks++; if (out_bus.wreg !== 2'b10) begin n_fail++; $display("FAIL coll_r0_lane0: got %b want 10", out_bus.wreg); end
    drive(1'b1, 5'd3, 5'd0, 2'b11, 32'h55, 32'h66);
    tick();
    n_checks++; if (out_bus.wreg !== 2'b01) begin n_fail++; $display("FAIL coll_r0_lane1: got %b want 01", out_bus.wreg); end
    drive(1'b1, 5'd6, 5'd6, 2'b01, 32'h77, 32'h88);
    tick();
    n_checks++; if (out_bus.wreg !== 2'b01) begin n_fail++; $display("FAIL coll_idle_higher: got %b want 01", out_bus.wreg); end
    in_bus.valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] c0;
    out_bus.ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 2'b11, $urandom, $urandom);
    tick();
    drive(1'b1, 5'd3, 5'd4, 2'b11, $urandom, $urandom);
    tick();
    c0 = retire_cnt;
    drive(1'b1, 5'd5, 5'd6, 2'b11, $urandom, $urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_bus.valid = 1'b0;
    n_checks++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_bus.valid); end
    n_checks++; if (dut_out() !== '0) begin n_fail++; $display("FAIL flush_fields: got %h want 0", dut_out()); end
    n_checks++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_bus.ready); end
    n_checks++; if (retire_cnt !== c0) begin n_fail++; $display("FAIL flush_retire: got %0d want %0d", retire_cnt, c0); end
    drive(1'b1, 5'd8, 5'd9, 2'b11, $urandom, $urandom);
    tick();
    in_bus.valid = 1'b0;
    out_bus.ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (retire_cnt !== 4'(c0 + 4'd1) || out_bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_consume: got cnt=%0d valid=%b want cnt=%0d valid=0", retire_cnt, out_bus.valid, 4'(c0 + 4'd1));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_bus.ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), 5'd0, 2'b01, $urandom, $urandom);
      tick();
    end
    in_bus.valid = 1'b0;
    tick();
    n_checks++; if (retire_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_retire: got %0d want 1", retire_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom, $urandom);
      out_bus.ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      flush = 1'b0;
      n_checks++; if (dut_out() !== exp_out() || out_bus.valid !== (exp_q.size() > 0)) begin
        n_fail++; $display("FAIL rand_out cyc%0d: got v=%b %h want v=%b %h", i, out_bus.valid, dut_out(), exp_q.size() > 0, exp_out());
      end
      n_checks++; if (in_bus.ready !== (exp_q.size() < 2) || retire_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL rand_ctl cyc%0d: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", i, in_bus.ready, retire_cnt, exp_q.size() < 2, exp_cnt);
      end
    end
    in_bus.valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_bus.ready = 1'b1;
    in_bus.valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      tick();
      n_checks++; if (dut_out() !== exp_out() || out_bus.valid !== 1'b1 || in_bus.ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b cyc%0d: got v=%b rdy=%b %h want v=1 rdy=1 %h", i, out_bus.valid, in_bus.ready, dut_out(), exp_out());
      end
    end
    in_bus.valid = 1'b0;
    tick();
    n_checks++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_retire: got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    out_bus.ready = 1'b0;
    drive(1'b1, 5'd12, 5'd13, 2'b11, $urandom, $urandom);
    tick();
    drive(1'b1, 5'd14, 5'd15, 2'b11, $urandom, $urandom);
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (out_bus.valid !== 1'b0 || dut_out() !== '0) begin n_fail++; $display("FAIL midrst_out: got v=%b %h want v=0 0", out_bus.valid, dut_out()); end
    n_checks++; if (in_bus.ready !== 1'b1 || retire_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_ctl: got rdy=%b cnt=%0d want rdy=1 cnt=0", in_bus.ready, retire_cnt); end
    @(negedge clk);
    exp_q.delete();
    exp_cnt = '0;
    in_bus.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_bus.ready = 1'b0;
    exp_cnt = '0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_stream();
    test_backpressure();
    test_collision();
    test_flush();
    test_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
